// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding, CPU word type
// and the physical-memory data width.
// Latency: n/a (types only). Backpressure: n/a.
package rv32i_types;

  localparam int PMEM_WIDTH = 64;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    I_RD     = 3'd1,
    D_RD     = 3'd2,
    D_RMW_RD = 3'd3,
    D_RMW_WR = 3'd4,
    RESP     = 3'd5
  } arb_state_t;

endpackage

// File: rtl/mbe_merge.sv
// Byte-enable merge: overlays the enabled bytes of a 32-bit word onto one half of a doubleword.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: dword (original doubleword), word (new data), mbe (byte enables),
//        half (0 = low 32 bits, 1 = high 32 bits), merged (result).
module mbe_merge
  import rv32i_types::*;
(
  input  logic [PMEM_WIDTH-1:0] dword,
  input  rv32i_word             word,
  input  logic [3:0]            mbe,
  input  logic                  half,
  output logic [PMEM_WIDTH-1:0] merged
);

  always_comb begin
    merged = dword;
    for (int i = 0; i < 4; i++) begin
      if (mbe[i]) begin
        if (half) merged[32 + 8*i +: 8] = word[8*i +: 8];
        else      merged[8*i +: 8]      = word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU instruction port and data port onto one 64-bit physical memory port.
// Latency: read = grant cycle + pmem latency + resp cycle; write = read-modify-write (two pmem transactions).
// Backpressure: CPU holds request until its resp pulse; pmem request held until pmem_resp.
// Ports: clk/rst (sync, active-high); instr_* (CPU fetch); data_* (CPU load/store with
//        byte enables); pmem_* (physical memory, doubleword addressed).
// Build option: MEM_ARBITER_RR_EN selects round-robin between contending ports
//        (data first after reset); otherwise data always wins.
module mem_arbiter
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  // instruction port
  input  logic                  instr_read,
  input  logic [31:0]           instr_mem_address,
  output logic                  instr_mem_resp,
  output logic [31:0]           instr_mem_rdata,
  // data port
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [3:0]            data_mbe,
  input  logic [31:0]           data_mem_address,
  input  logic [31:0]           data_mem_wdata,
  output logic                  data_mem_resp,
  output logic [31:0]           data_mem_rdata,
  // physical memory
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [31:0]           pmem_address,
  output logic [PMEM_WIDTH-1:0] pmem_wdata,
  input  logic [PMEM_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state, state_nxt;
  logic [31:2]           addr_q;
  rv32i_word             wdata_q;
  logic [3:0]            mbe_q;
  logic                  is_data_q;
  logic [PMEM_WIDTH-1:0] dword_q;
  rv32i_word             instr_rdata_q;
  rv32i_word             data_rdata_q;

  logic                  d_req, i_req, pick_data, grant;
  rv32i_word             sel_word;
  logic [PMEM_WIDTH-1:0] merged;

  assign d_req = data_read | data_write;
  assign i_req = instr_read;

`ifdef MEM_ARBITER_RR_EN
  // Set after data wins a contended grant, so instruction wins the next one.
  logic rr_instr_turn_q;
  assign pick_data = d_req & (~i_req | ~rr_instr_turn_q);
`else
  assign pick_data = d_req;
`endif

  assign grant    = (state == IDLE) & (d_req | i_req);
  assign sel_word = addr_q[2] ? pmem_rdata[63:32] : pmem_rdata[31:0];

  mbe_merge u_mbe_merge (
    .dword  (pmem_rdata),
    .word   (wdata_q),
    .mbe    (mbe_q),
    .half   (addr_q[2]),
    .merged (merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_data) begin
          // Write wins over a simultaneous read; an all-zero mask needs no pmem traffic.
          if (data_write) state_nxt = (data_mbe == 4'h0) ? RESP : D_RMW_RD;
          else            state_nxt = D_RD;
        end else if (i_req) begin
          state_nxt = I_RD;
        end
      end
      I_RD, D_RD: if (pmem_resp) state_nxt = RESP;
      D_RMW_RD:   if (pmem_resp) state_nxt = D_RMW_WR;
      D_RMW_WR:   if (pmem_resp) state_nxt = RESP;
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_address   = 32'h0;
    pmem_wdata     = '0;
    instr_mem_resp = 1'b0;
    data_mem_resp  = 1'b0;
    unique case (state)
      I_RD, D_RD, D_RMW_RD: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_q[31:3], 3'b000};
      end
      D_RMW_WR: begin
        pmem_write   = 1'b1;
        pmem_address = {addr_q[31:3], 3'b000};
        pmem_wdata   = dword_q;
      end
      RESP: begin
        instr_mem_resp = ~is_data_q;
        data_mem_resp  = is_data_q;
      end
      default: ;
    endcase
  end

  // Request capture and response data
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      mbe_q         <= '0;
      is_data_q     <= 1'b0;
      dword_q       <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      if (grant) begin
        addr_q    <= pick_data ? data_mem_address[31:2] : instr_mem_address[31:2];
        wdata_q   <= data_mem_wdata;
        mbe_q     <= data_mbe;
        is_data_q <= pick_data;
      end
      if (pmem_resp) begin
        if (state == I_RD)     instr_rdata_q <= sel_word;
        if (state == D_RD)     data_rdata_q  <= sel_word;
        if (state == D_RMW_RD) dword_q       <= merged;
      end
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (rst)                     rr_instr_turn_q <= 1'b0;
    else if (grant & d_req & i_req) rr_instr_turn_q <= pick_data;
  end
`endif

  assign instr_mem_rdata = instr_rdata_q;
  assign data_mem_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and randomized transactions checked
// against a doubleword memory model and per-transaction expectations.
// Latency/backpressure: bench plays the CPU and a variable-latency pmem.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        data_read, data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address, data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata, pmem_rdata;
  logic        pmem_resp;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .instr_read(instr_read), .instr_mem_address(instr_mem_address),
    .instr_mem_resp(instr_mem_resp), .instr_mem_rdata(instr_mem_rdata),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int lat = 1;
  int acc_cnt = 0;
  int i_resp_n, d_resp_n;
  logic [31:0] i_rdata_seen, d_rdata_seen;
  logic [31:0] last_i = 32'h0, last_d = 32'h0;
  logic [63:0] mem [logic [28:0]];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [63:0] wr_data_log[$];
  byte         order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_peek(input logic [28:0] k, output logic [63:0] v);
    if (!mem.exists(k)) mem[k] = {$urandom, $urandom};
    v = mem[k];
  endtask

  // One clock: behave as pmem for the current cycle, log CPU responses, advance.
  task automatic tick();
    logic [63:0] v;
    pmem_resp  = 1'b0;
    pmem_rdata = {$urandom, $urandom};
    if (pmem_read || pmem_write) begin
      if (pmem_read && pmem_write) overlap++;
      acc_cnt++;
      if (acc_cnt >= lat) begin
        acc_cnt   = 0;
        pmem_resp = 1'b1;
        if (pmem_read) begin
          mem_peek(pmem_address[31:3], v);
          pmem_rdata = v;
          rd_log.push_back(pmem_address);
        end else begin
          wr_addr_log.push_back(pmem_address);
          wr_data_log.push_back(pmem_wdata);
          mem[pmem_address[31:3]] = pmem_wdata;
        end
      end
    end else begin
      acc_cnt = 0;
    end
    if (instr_mem_resp) begin i_resp_n++; i_rdata_seen = instr_mem_rdata; order.push_back("I"); end
    if (data_mem_resp)  begin d_resp_n++; d_rdata_seen = data_mem_rdata;  order.push_back("D"); end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); order.delete();
    i_resp_n = 0; d_resp_n = 0;
  endtask

  // One CPU transaction, request dropped and CPU fields scrambled right after the grant.
  task automatic do_req(input bit instr, input bit wr, input bit rd_too, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input int l, input string tag);
    logic [63:0] dw, exp_dw;
    logic [31:0] exp_word;
    int exp_tick, resp_tick, exp_rd, exp_wr;
    mem_peek(a[31:3], dw);
    exp_word = a[2] ? dw[63:32] : dw[31:0];
    exp_dw = dw;
    for (int b = 0; b < 4; b++)
      if (be[b]) exp_dw[(a[2] ? 32 : 0) + 8*b +: 8] = wd[8*b +: 8];
    if (instr || !wr)   begin exp_tick = l + 1;     exp_rd = 1; exp_wr = 0; end
    else if (be == 4'h0) begin exp_tick = 1;         exp_rd = 0; exp_wr = 0; end
    else                begin exp_tick = 2 * l + 1; exp_rd = 1; exp_wr = 1; end

    lat = l;
    clear_logs();
    if (instr) begin
      instr_read = 1'b1; instr_mem_address = a;
    end else begin
      data_write = wr; data_read = !wr || rd_too;
      data_mem_address = a; data_mem_wdata = wd; data_mbe = be;
    end
    tick();
    instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    instr_mem_address = $urandom; data_mem_address = $urandom;
    data_mem_wdata = $urandom; data_mbe = 4'($urandom);

    resp_tick = -1;
    for (int t = 1; t < 60 && resp_tick < 0; t++) begin
      if (instr_mem_resp || data_mem_resp) resp_tick = t;
      tick();
    end
    tick();

    chk($sformatf("%s latency", tag), 64'(resp_tick), 64'(exp_tick));
    chk($sformatf("%s instr_resp count", tag), 64'(i_resp_n), instr ? 64'd1 : 64'd0);
    chk($sformatf("%s data_resp count", tag), 64'(d_resp_n), instr ? 64'd0 : 64'd1);
    if (instr) begin
      last_i = exp_word;
      chk($sformatf("%s instr rdata", tag), 64'(i_rdata_seen), 64'(exp_word));
    end else begin
      if (!wr) last_d = exp_word;
      chk($sformatf("%s data rdata", tag), 64'(d_rdata_seen), 64'(last_d));
    end
    chk($sformatf("%s pmem reads", tag), 64'(rd_log.size()), 64'(exp_rd));
    if (rd_log.size() > 0) chk($sformatf("%s read addr", tag), 64'(rd_log[0]), 64'({a[31:3], 3'b000}));
    chk($sformatf("%s pmem writes", tag), 64'(wr_addr_log.size()), 64'(exp_wr));
    if (exp_wr == 1 && wr_addr_log.size() > 0) begin
      chk($sformatf("%s write addr", tag), 64'(wr_addr_log[0]), 64'({a[31:3], 3'b000}));
      chk($sformatf("%s write data", tag), wr_data_log[0], exp_dw);
    end
    if (exp_wr == 1) mem[a[31:3]] = exp_dw;
    chk($sformatf("%s instr rdata hold", tag), 64'(instr_mem_rdata), 64'(last_i));
    chk($sformatf("%s data rdata hold", tag), 64'(data_mem_rdata), 64'(last_d));
  endtask

  // Instruction and data reads raised together; each held until its own resp.
  task automatic contested(input logic [31:0] ai, input logic [31:0] ad, input bit instr_first, input string tag);
    logic [63:0] vi, vd;
    mem_peek(ai[31:3], vi);
    mem_peek(ad[31:3], vd);
    lat = 2;
    clear_logs();
    instr_read = 1'b1; instr_mem_address = ai;
    data_read  = 1'b1; data_mem_address  = ad;
    for (int t = 0; t < 40 && order.size() < 2; t++) begin
      if (instr_mem_resp) instr_read = 1'b0;
      if (data_mem_resp)  data_read  = 1'b0;
      tick();
    end
    instr_read = 1'b0; data_read = 1'b0;
    tick();
    last_i = ai[2] ? vi[63:32] : vi[31:0];
    last_d = ad[2] ? vd[63:32] : vd[31:0];
    chk($sformatf("%s resp count", tag), 64'(order.size()), 64'd2);
    if (order.size() > 0)
      chk($sformatf("%s first served", tag), 64'(order[0]), instr_first ? 64'("I") : 64'("D"));
    chk($sformatf("%s instr rdata", tag), 64'(i_rdata_seen), 64'(last_i));
    chk($sformatf("%s data rdata", tag), 64'(d_rdata_seen), 64'(last_d));
  endtask

  initial begin
    rst = 1'b1;
    instr_read = 1'b0; instr_mem_address = 32'h0;
    data_read = 1'b0; data_write = 1'b0; data_mbe = 4'h0;
    data_mem_address = 32'h0; data_mem_wdata = 32'h0;
    pmem_rdata = 64'h0; pmem_resp = 1'b0;
    i_rdata_seen = 32'h0; d_rdata_seen = 32'h0;
    clear_logs();
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("reset pmem_read", 64'(pmem_read), 64'd0);
    chk("reset pmem_write", 64'(pmem_write), 64'd0);
    chk("reset pmem_address", 64'(pmem_address), 64'd0);
    chk("reset pmem_wdata", pmem_wdata, 64'd0);
    chk("reset resp", 64'({instr_mem_resp, data_mem_resp}), 64'd0);
    chk("reset rdata", 64'({instr_mem_rdata, data_mem_rdata}), 64'd0);

    // Known-vector fetch and partial store into the same doubleword
    mem[29'h60 >> 3] = 64'h11112222_33334444;
    do_req(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 4'h0, 3, "ifetch 0x60");
    do_req(1'b0, 1'b1, 1'b0, 32'h64, 32'hAABBCCDD, 4'b0110, 2, "store 0x64");
    chk("store 0x64 merged image", mem[29'h60 >> 3], 64'h11BBCC22_33334444);
    do_req(1'b0, 1'b0, 1'b0, 32'h64, 32'h0, 4'h0, 1, "load 0x64");
    do_req(1'b0, 1'b1, 1'b0, 32'h68, 32'h12345678, 4'h0, 2, "store mbe0");

    // Contention: data first, then the second pair depends on round-robin
    contested(32'h200, 32'h304, 1'b0, "pair1");
    contested(32'h204, 32'h300, RR, "pair2");

    // Randomized traffic over a small address window
    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_req(kind == 0, kind == 2, 1'($urandom), 32'h100 + 32'(4 * $urandom_range(0, 15)),
             $urandom, 4'($urandom), $urandom_range(1, 4), $sformatf("rnd%0d", n));
    end

    // Reset while a store waits on its read half
    clear_logs();
    lat = 1000;
    data_write = 1'b1; data_mbe = 4'hF; data_mem_address = 32'h80; data_mem_wdata = $urandom;
    tick();
    data_write = 1'b0;
    tick(); tick(); tick();
    chk("midrst pre pmem_read", 64'(pmem_read), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_cnt = 0;
    chk("midrst pmem_read", 64'(pmem_read), 64'd0);
    chk("midrst pmem_write", 64'(pmem_write), 64'd0);
    chk("midrst pmem_address", 64'(pmem_address), 64'd0);
    chk("midrst rdata", 64'({instr_mem_rdata, data_mem_rdata}), 64'd0);
    tick(); tick(); tick();
    chk("midrst no resp", 64'(i_resp_n + d_resp_n), 64'd0);
    chk("midrst no write", 64'(wr_addr_log.size()), 64'd0);
    last_i = 32'h0; last_d = 32'h0;
    do_req(1'b0, 1'b0, 1'b0, 32'h84, 32'h0, 4'h0, 2, "post-rst load");
    do_req(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 1, "post-rst fetch");

    chk("read/write overlap cycles", 64'(overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-002 SHALL have instr_read in 1, instr_mem_address in 32, instr_mem_resp out 1 and instr_mem_rdata out 32 (CPU instruction port).
REQ-003 SHALL have data_read in 1, data_write in 1, data_mbe in 4, data_mem_address in 32, data_mem_wdata in 32, data_mem_resp out 1 and data_mem_rdata out 32 (CPU data port).
REQ-004 SHALL have pmem_read out 1, pmem_write out 1, pmem_address out 32, pmem_wdata out 64, pmem_rdata in 64 and pmem_resp in 1 (physical memory).

Function
REQ-005 SHALL use states IDLE, I_RD, D_RD, D_RMW_RD, D_RMW_WR and RESP.
REQ-006 In IDLE, the arbiter SHALL grant one pending port, capture its address, wdata and mbe, and move next cycle.
- I grant -> I_RD; D read -> D_RD; D write -> D_RMW_RD.
REQ-007 Default grant policy SHALL be fixed data priority over instruction.
REQ-008 SHALL drive pmem_address = {captured_addr[31:3], 3'b000} during any pmem access.
REQ-009 SHALL hold pmem_read high in I_RD, D_RD and D_RMW_RD until pmem_resp is sampled high.
REQ-010 On pmem_resp in I_RD or D_RD, SHALL register word = addr[2] ? rdata[63:32] : rdata[31:0] and go to RESP.
REQ-011 On pmem_resp in D_RMW_RD, SHALL register the doubleword with the mbe-selected bytes replaced from wdata in the addr[2] half, then go to D_RMW_WR.
REQ-012 SHALL hold pmem_write high with the merged doubleword in D_RMW_WR until pmem_resp, then go to RESP.
REQ-013 In RESP, SHALL pulse exactly one of instr_mem_resp or data_mem_resp for one cycle, with rdata valid that cycle, then return to IDLE.
- A request still high in the cycle after RESP SHALL be treated as new.
REQ-014 The read-to-resp latency SHALL be 2 cycles plus the pmem latency; a write SHALL take two pmem transactions.
REQ-015 pmem_read and pmem_write SHALL never be high simultaneously and SHALL be low outside the states named above.
REQ-016 If data_read and data_write are both high, the write SHALL be serviced.
REQ-017 A write with data_mbe = 4'h0 SHALL go IDLE -> RESP with no pmem traffic.
REQ-018 Captured request fields SHALL remain constant from grant to resp, regardless of the CPU inputs.
REQ-019 CPU rdata outputs SHALL hold their last value when not in RESP.

Reset
REQ-020 On rst, SHALL enter IDLE and clear all outputs and internal registers to 0.
REQ-021 A rst in mid-transaction SHALL abandon the transaction; pmem_read and pmem_write SHALL be low in the cycle after the rst edge and no resp SHALL be issued.

Configuration
REQ-022 With MEM_ARBITER_RR_EN defined, grants SHALL alternate round-robin when both ports request, starting with data after reset.
REQ-023 Without MEM_ARBITER_RR_EN, fixed data priority per REQ-007 SHALL apply.

Structure
REQ-024 The arb_state_t enum and the PMEM_WIDTH=64 constant SHALL live in rv32i_types; the word type SHALL be rv32i_word.
REQ-025 Byte merging SHALL be a combinational sub-module named mbe_merge (inputs dword, word, mbe, half; output merged dword).

Verification
REQ-026 Instruction read at 0x60 with pmem_rdata=0x11112222_33334444 and 3-cycle pmem latency -> pmem_address=0x60; instr_mem_rdata=0x33334444 on a single resp pulse.
REQ-027 Data write at 0x64, mbe=4'b0110, wdata=0xAABBCCDD over 0x11112222_33334444 -> one read, then a write of 0x11BBCC22_33334444; data_mem_resp pulses once.
REQ-028 Simultaneous instruction read and data read -> data is served first; with RR_EN, the next simultaneous pair is served instruction first.
REQ-029 Write with mbe=0 -> data_mem_resp in the 2nd cycle; pmem_read and pmem_write stay low.
REQ-030 rst asserted while waiting on pmem_resp in D_RMW_RD -> IDLE next cycle, all outputs 0, no resp, and the next request is served normally.
